// File: rtl/hmac_212_stream_if.sv
// Word-serial wrapper around the 212-byte HMAC-SHA256 stage: gathers NUM_WORDS input
// words into a wide message, holds enable until hash_done, then streams the 256-bit result.
module hmac_212_stream_if #(
  parameter int NUM_WORDS = 53,
  parameter int TIMEOUT   = 4096
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [31:0]               in_word,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [32*NUM_WORDS-1:0]   data_out,
  output logic                      enable,
  input  logic [255:0]              hash_in,
  input  logic                      hash_done,
  output logic [31:0]               out_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int DW   = 32 * NUM_WORDS;
  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WC_W-1:0]   wc_reg, wc_next;
  logic [31:0]       tc_reg, tc_next;
  logic [2:0]        j_reg, j_next;
  logic [255:0]      result_reg;
  logic              timeout_err_reg, timeout_err_next;
  logic [31:0]       data_words_reg [NUM_WORDS];
  logic [NUM_WORDS-1:0] word_we;
  logic [31:0]       res_words [8];

  logic in_fire;
  logic out_fire;
  logic timeout_hit;

  // Handshakes only count in the state that owns the corresponding channel.
  assign in_fire  = (state_reg == ST_LOAD) && in_valid;
  assign out_fire = (state_reg == ST_DRAIN) && out_ready;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timeout_hit = (tc_reg == 32'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_reg <= ST_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: begin
        if (in_fire && (wc_reg == WC_LAST)) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (hash_done)        state_next = ST_DRAIN;
        else if (timeout_hit) state_next = ST_LOAD;
      end
      ST_DRAIN: begin
        if (out_fire && (j_reg == 3'd7)) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  // Outputs decode straight from the state register, so none depends on in_valid/out_ready.
  always_comb begin
    in_ready  = 1'b0;
    enable    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_RUN:   enable    = 1'b1;
      ST_DRAIN: out_valid = 1'b1;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  // Counter next values; each counter is cleared whenever its state is left.
  always_comb begin
    wc_next          = '0;
    tc_next          = '0;
    j_next           = '0;
    timeout_err_next = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        wc_next = wc_reg;
        if (in_fire) begin
          wc_next = (wc_reg == WC_LAST) ? '0 : wc_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (state_next == ST_RUN) begin
          tc_next = (tc_reg == 32'hFFFF_FFFF) ? tc_reg : tc_reg + 32'd1;
        end
        timeout_err_next = !hash_done && timeout_hit;
      end
      ST_DRAIN: begin
        if (out_fire) begin
          j_next = (j_reg == 3'd7) ? 3'd0 : j_reg + 3'd1;
        end else begin
          j_next = j_reg;
        end
      end
      default: wc_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wc_reg          <= '0;
      tc_reg          <= '0;
      j_reg           <= '0;
      timeout_err_reg <= 1'b0;
      result_reg      <= '0;
    end else begin
      wc_reg          <= wc_next;
      tc_reg          <= tc_next;
      j_reg           <= j_next;
      timeout_err_reg <= timeout_err_next;
      if ((state_reg == ST_RUN) && hash_done) begin
        result_reg <= hash_in;
      end
    end
  end

  assign timeout_err = timeout_err_reg;

  // One write strobe per message word; word 0 lands in the top 32 bits of data_out.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign word_we[gi] = in_fire && (wc_reg == WC_W'(gi));
      assign data_out[DW-1-32*gi -: 32] = data_words_reg[gi];
    end
    for (gi = 0; gi < 8; gi++) begin : g_res
      assign res_words[gi] = result_reg[255-32*gi -: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (n_rst) begin
        data_words_reg[i] <= '0;
      end else if (word_we[i]) begin
        data_words_reg[i] <= in_word;
      end
    end
  end

  assign out_word = res_words[j_reg];

endmodule

// File: tb/tb_hmac_212_stream_if.sv
// Scoreboarded bench for hmac_212_stream_if: stimulus pushes expected message/result
// words into queues, a negedge monitor pops and compares on each DUT presentation.
module tb_hmac_212_stream_if;

  localparam int NW = 53;
  localparam int DW = 32 * NW;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [31:0]     in_word;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   data_out;
  logic            enable;
  logic [255:0]    hash_in;
  logic            hash_done;
  logic [31:0]     out_word;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  logic [31:0]   exp_word_q [$];
  logic [DW-1:0] exp_data_q [$];

  hmac_212_stream_if #(.NUM_WORDS(NW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .enable     (enable),
    .hash_in    (hash_in),
    .hash_done  (hash_done),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] exp);
    int bad;
    logic [31:0] g, e;
    bad = -1;
    g = '0;
    e = '0;
    for (int k = NW - 1; k >= 0; k--) begin
      if (data_out[DW-1-32*k -: 32] !== exp[DW-1-32*k -: 32]) begin
        bad = k;
        g = data_out[DW-1-32*k -: 32];
        e = exp[DW-1-32*k -: 32];
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got %h expected %h", name, bad, g, e);
    end else begin
      $display("message check %s ok", name);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
    return r;
  endfunction

  // Monitor: compares message on RUN entry and every result word on its handshake.
  logic        en_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] word_prev = '0;
  always @(negedge clk) begin
    if (n_rst !== 1'b0) begin
      en_prev    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (enable && !en_prev) begin
        if (exp_data_q.size() == 0) begin
          chk("unexpected_enable", 32'd1, 32'd0);
        end else begin
          chk_data("data_out", exp_data_q.pop_front());
        end
      end
      if (enable) chk("in_ready_in_run", {31'd0, in_ready}, 32'd0);
      chk("spurious_out_valid", {31'd0, out_valid && (exp_word_q.size() == 0)}, 32'd0);
      if (stall_prev) chk("out_word_hold", out_word, word_prev);
      if (out_valid && out_ready && exp_word_q.size() != 0) begin
        logic [31:0] e;
        e = exp_word_q.pop_front();
        chk("out_word", out_word, e);
        $display("out word %h expected %h", out_word, e);
      end
      stall_prev = out_valid && !out_ready;
      word_prev  = out_word;
      en_prev    = enable;
    end
  end

  task automatic do_reset();
    n_rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    hash_done = 1'b0;
    exp_word_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_enable", {31'd0, enable}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk_data("rst_data_out", '0);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
  endtask

  // Sends nwords; a full message is expected in data_out in arrival order.
  task automatic send_msg(input int nwords, input bit gapped, input bit seq);
    logic [DW-1:0] acc;
    logic [31:0]   w;
    int            waitc;
    acc = '0;
    for (int k = 0; k < nwords; k++) begin
      w = seq ? (32'h1000_0000 + 32'(k)) : $urandom();
      in_word  = w;
      in_valid = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!in_ready && waitc < 50) begin
        @(posedge clk); #1; @(negedge clk);
        waitc++;
      end
      if (!in_ready) chk("in_ready_wait", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      acc = {acc[DW-33:0], w};
      if (k == NW - 1) exp_data_q.push_back(acc);
      $display("in word %0d = %h", k, w);
      if (gapped && k != nwords - 1) begin
        in_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          hash_in   = rand256();
          hash_done = 1'b1;
        end
        @(posedge clk);
        #1;
        hash_done = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (nwords == NW) begin
      @(negedge clk);
      chk("enable_after_last", {31'd0, enable}, 32'd1);
      chk("busy_after_last", {31'd0, busy}, 32'd1);
      chk("in_ready_after_last", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // hash_done is raised lat cycles after the post-message check (RUN cycle tc = lat+1).
  task automatic do_hash(input int lat, input logic [255:0] h);
    in_valid = 1'b1;
    in_word  = $urandom();
    repeat (lat) begin @(posedge clk); #1; end
    hash_in   = h;
    hash_done = 1'b1;
    for (int j = 0; j < 8; j++) exp_word_q.push_back(h[255-32*j -: 32]);
    @(posedge clk);
    #1;
    hash_done = 1'b0;
    hash_in   = rand256();
    in_valid  = 1'b0;
    @(negedge clk);
    chk("enable_after_done", {31'd0, enable}, 32'd0);
    chk("out_valid_after_done", {31'd0, out_valid}, 32'd1);
    chk("no_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held, 1: toggling 1,0,1,..., 2: random.
  task automatic drain(input int mode, input int nmax);
    int n, cyc;
    n = 0;
    cyc = 0;
    while (n < nmax && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) n++;
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(n), 32'(nmax));
    if (nmax == 8) begin
      @(negedge clk);
      chk("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
      chk("busy_after_drain", {31'd0, busy}, 32'd0);
      chk("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt;
    bit seen;
    in_word   = '0;
    hash_in   = '0;
    do_reset();

    // Back-to-back counting message, fixed result, toggled backpressure.
    send_msg(NW, 1'b0, 1'b1);
    do_hash(5, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
    drain(1, 8);

    // Random gapped messages with stray hash_done during LOAD.
    for (int m = 0; m < 3; m++) begin
      send_msg(NW, 1'b1, 1'b0);
      do_hash($urandom_range(0, 13), rand256());
      drain(2, 8);
    end

    // hash_done on the same cycle the timeout would fire.
    send_msg(NW, 1'b0, 1'b0);
    do_hash(TO - 2, rand256());
    drain(0, 8);

    // Timeout: no hash_done at all.
    send_msg(NW, 1'b0, 1'b0);
    cnt = 1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (timeout_err) begin
        seen = 1'b1;
        chk("enable_at_timeout", {31'd0, enable}, 32'd0);
        chk("in_ready_at_timeout", {31'd0, in_ready}, 32'd1);
      end else if (enable) begin
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    chk("timeout_seen", {31'd0, seen}, 32'd1);
    chk("enable_cycles", 32'(cnt), 32'(TO));
    @(negedge clk);
    chk("timeout_pulse_width", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1;
    send_msg(NW, 1'b0, 1'b0);
    do_hash(3, rand256());
    drain(2, 8);

    // Reset mid-message, then mid-drain.
    send_msg(21, 1'b0, 1'b0);
    do_reset();
    send_msg(NW, 1'b0, 1'b1);
    do_hash(2, rand256());
    drain(0, 3);
    do_reset();
    send_msg(NW, 1'b0, 1'b0);
    do_hash(4, rand256());
    drain(1, 8);

    chk("result_queue_empty", 32'(exp_word_q.size()), 32'd0);
    chk("data_queue_empty", 32'(exp_data_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
